instr_fetch_unit: RTL and testbench

Instruction fetch front end for the pipelined RV32I core: owns the PC, issues word reads to instruction memory, buffers returned instructions with their PCs in a small prefetch FIFO, and presents them to the decode stage, where the opcode controller consumes `instr[6:0]`. Decode applies backpressure with `instr_ready`. Execute redirects fetch on taken branch/JAL/JALR with `redirect_valid`/`redirect_pc`.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, the canonical NOP and the fetch
// entry record passed from the fetch front end to decode.
package riscv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // True for the nine base opcodes the controller understands.
   function automatic logic opcode_supported(input logic [6:0] opc);
      logic ok;
      case (opc)
         OPC_OP, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_BRANCH,
         OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: ok = 1'b1;
         default:                              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch front-end bus: instruction memory port, decode handshake and the
// redirect request from execute. master = fetch unit, slave = its environment.
interface instr_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        instr_illegal;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_illegal,
      input  imem_rdata, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_illegal,
      output imem_rdata, instr_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries. Synchronous flush beats a same-cycle
// push; reset and flush both empty it. DEPTH must be a power of two.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            push,
   input  fetch_entry_t    push_data,
   input  logic            pop,
   output fetch_entry_t    head,
   output logic [CntW-1:0] count,
   output logic            empty,
   output logic            full
);

   fetch_entry_t    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok, pop_ok;

   assign push_ok = push && !flush;
   assign pop_ok  = pop && !flush && (count_q != '0);

   // Occupancy update from the accepted push/pop pair.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   // Storage array, no reset needed: occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch front end: owns the PC, issues single-cycle word
// reads, buffers responses in fetch_fifo and hands them to decode.
// Optional feature macro: IFU_ILLEGAL_OP_EN builds the head-opcode legality
// check; without it instr_illegal is tied low.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                clk,
   input logic                reset,
   instr_fetch_unit_if.master bus
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [31:0]     pc_q, pc_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic            kill_q, kill_d;
   logic [CntW-1:0] count, occupancy;
   logic            empty, full;
   logic            issue, push, pop, head_valid;
   fetch_entry_t    head, push_data;

   // count + inflight never exceeds DEPTH, so a landing response always fits.
   assign occupancy  = count + CntW'(inflight_q);
   assign issue      = !reset && !bus.redirect_valid && !full
                       && (occupancy < CntW'(DEPTH));
   assign head_valid = !empty && !reset;
   // A response in a redirect cycle is dropped by the FIFO's flush priority.
   assign push       = inflight_q && !kill_q;
   assign pop        = head_valid && bus.instr_ready && !bus.redirect_valid;
   assign push_data  = '{pc: req_pc_q, instr: bus.imem_rdata};

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   // Next PC: redirect wins over sequential advance; remember the issued PC.
   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue;
      // Anything landing right after a redirect belongs to the old path.
      kill_d     = bus.redirect_valid;
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc & ~32'h3;
      end else if (issue) begin
         pc_d     = pc_q + 32'd4;
         req_pc_d = pc_q;
      end
   end

   // Fetch state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC & ~32'h3;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
      end
   end

   assign bus.imem_req    = issue;
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = head_valid;
   assign bus.instr       = head_valid ? head.instr : NOP_INSTR;
   assign bus.instr_pc    = head_valid ? head.pc : 32'h0;

`ifdef IFU_ILLEGAL_OP_EN
   assign bus.instr_illegal = head_valid && !opcode_supported(head.instr[6:0]);
`else
   assign bus.instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=4, RESET_PC=0x100) with a
// zero-wait memory model returning an address-derived word.
module tb_instr_fetch_unit;

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total  = 0;

`ifdef IFU_ILLEGAL_OP_EN
   localparam logic ILL_EN = 1'b1;
`else
   localparam logic ILL_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h300) return 32'h0000_007F;
      if (a == 32'h304) return 32'h0000_0033;
      return {a[24:0], 7'b0010011};
   endfunction

   // Memory: data valid exactly one cycle after an accepted request.
   always @(posedge clk)
      bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

   task automatic test_reset();
      reset = 1'b1; bus.instr_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.imem_req); else passed++;
      total++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.instr_valid); else passed++;
      total++; if (bus.instr !== 32'h13) $display("FAIL rst_instr got %h want 00000013", bus.instr); else passed++;
      total++; if (bus.instr_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", bus.instr_pc); else passed++;
      total++; if (bus.instr_illegal !== 1'b0) $display("FAIL rst_ill got %b want 0", bus.instr_illegal); else passed++;
   endtask

   // Reset release with ready=1: one request and, from cycle 2, one instruction per cycle.
   task automatic test_stream();
      @(negedge clk); reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 + 4 * c)
            $display("FAIL stream_req c%0d got %b/%h want 1/%h", c, bus.imem_req, bus.imem_addr, 32'h100 + 4 * c);
         else passed++;
         total++; if (bus.instr_valid !== (c >= 2))
            $display("FAIL stream_valid c%0d got %b want %b", c, bus.instr_valid, c >= 2);
         else passed++;
         if (c >= 2) begin
            total++; if (bus.instr_pc !== 32'h100 + 4 * (c - 2) || bus.instr !== mem_word(32'h100 + 4 * (c - 2)))
               $display("FAIL stream_head c%0d got %h/%h want %h", c, bus.instr_pc, bus.instr, 32'h100 + 4 * (c - 2));
            else passed++;
         end
         @(negedge clk);
      end
   endtask

   // ready=0: exactly four requests, then one pop re-opens exactly one slot.
   task automatic test_backpressure();
      reset = 1'b1; bus.instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         total++; if (bus.imem_req !== (c < 4) || (c < 4 && bus.imem_addr !== 32'h100 + 4 * c))
            $display("FAIL bp_req c%0d got %b/%h want %b", c, bus.imem_req, bus.imem_addr, c < 4);
         else passed++;
         @(negedge clk);
      end
      // cycle 8: one pop
      bus.instr_ready = 1'b1; #1;
      total++; if (bus.imem_req !== 1'b0 || bus.instr_pc !== 32'h100)
         $display("FAIL bp_pop got %b/%h want 0/00000100", bus.imem_req, bus.instr_pc);
      else passed++;
      @(negedge clk); bus.instr_ready = 1'b0; #1;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h110 || bus.instr_pc !== 32'h104)
         $display("FAIL bp_refill got %b/%h/%h want 1/00000110/00000104", bus.imem_req, bus.imem_addr, bus.instr_pc);
      else passed++;
   endtask

   // Redirect with three buffered entries and the 0x110 response in flight.
   task automatic test_redirect_full();
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h2003; #1;
      total++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1)
         $display("FAIL rf_t0 got %b/%b want 0/1", bus.imem_req, bus.instr_valid);
      else passed++;
      @(negedge clk); bus.redirect_valid = 1'b0; #1;
      total++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h2000)
         $display("FAIL rf_t1 got %b/%b/%h want 0/1/00002000", bus.instr_valid, bus.imem_req, bus.imem_addr);
      else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h2004)
         $display("FAIL rf_t2 got %b/%h want 0/00002004", bus.instr_valid, bus.imem_addr);
      else passed++;
      @(negedge clk); bus.instr_ready = 1'b1; #1;
      total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h2000 || bus.instr !== mem_word(32'h2000))
         $display("FAIL rf_t3 got %b/%h/%h want 1/00002000", bus.instr_valid, bus.instr_pc, bus.instr);
      else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_pc !== 32'h2004)
         $display("FAIL rf_t4 got %h want 00002004", bus.instr_pc);
      else passed++;
   endtask

   // Redirect in a cycle where the head would otherwise be consumed.
   task automatic test_redirect_pop();
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3000; #1;
      total++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0)
         $display("FAIL rp_t0 got %b/%b want 1/0", bus.instr_valid, bus.imem_req);
      else passed++;
      @(negedge clk); bus.redirect_valid = 1'b0; #1;
      total++; if (bus.instr_valid !== 1'b0) $display("FAIL rp_t1 got %b want 0", bus.instr_valid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_valid !== 1'b0) $display("FAIL rp_t2 got %b want 0", bus.instr_valid); else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h3000)
         $display("FAIL rp_t3 got %b/%h want 1/00003000", bus.instr_valid, bus.instr_pc);
      else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_pc !== 32'h3004) $display("FAIL rp_t4 got %h want 00003004", bus.instr_pc); else passed++;
   endtask

   // Two redirects on consecutive cycles: the second target wins.
   task automatic test_back_to_back();
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h4000; #1;
      @(negedge clk); bus.redirect_pc = 32'h5000; #1;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL b2b_t1 got %b want 0", bus.imem_req); else passed++;
      @(negedge clk); bus.redirect_valid = 1'b0; #1;
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5000 || bus.instr_valid !== 1'b0)
         $display("FAIL b2b_t2 got %b/%h/%b want 1/00005000/0", bus.imem_req, bus.imem_addr, bus.instr_valid);
      else passed++;
      @(negedge clk); #1;
      @(negedge clk); #1;
      total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h5000)
         $display("FAIL b2b_t4 got %b/%h want 1/00005000", bus.instr_valid, bus.instr_pc);
      else passed++;
   endtask

   // PC wraps from 0xFFFF_FFFC to 0; low redirect bits are ignored.
   task automatic test_wrap();
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE; #1;
      @(negedge clk); bus.redirect_valid = 1'b0; #1;
      total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_a0 got %h want fffffffc", bus.imem_addr); else passed++;
      @(negedge clk); #1;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_a1 got %h want 00000000", bus.imem_addr); else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr !== mem_word(32'hFFFF_FFFC))
         $display("FAIL wrap_h0 got %h/%h want fffffffc", bus.instr_pc, bus.instr);
      else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b1)
         $display("FAIL wrap_h1 got %h/%b want 00000000/1", bus.instr_pc, bus.instr_valid);
      else passed++;
   endtask

   // Head opcode 0x7F is unsupported, 0x33 is a legal R-type.
   task automatic test_illegal();
      @(negedge clk); bus.instr_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300; #1;
      @(negedge clk); bus.redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      bus.instr_ready = 1'b1; #1;
      total++; if (bus.instr_pc !== 32'h300 || bus.instr !== 32'h7F || bus.instr_illegal !== ILL_EN)
         $display("FAIL ill_7f got %h/%h/%b want 00000300/0000007f/%b", bus.instr_pc, bus.instr, bus.instr_illegal, ILL_EN);
      else passed++;
      @(negedge clk); #1;
      total++; if (bus.instr_pc !== 32'h304 || bus.instr !== 32'h33 || bus.instr_illegal !== 1'b0)
         $display("FAIL ill_33 got %h/%h/%b want 00000304/00000033/0", bus.instr_pc, bus.instr, bus.instr_illegal);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_redirect_pop();
      test_back_to_back();
      test_wrap();
      test_illegal();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
